// File: rtl/game_of_life.sv
// rtl/game_of_life.sv - 8x8 toroidal Conway Game of Life engine, one generation per clock
module game_of_life #(
    parameter logic [63:0] SEED = 64'h0000_0000_0007_0402
) (
    input  logic        clk,
    input  logic        start,
    output logic [63:0] outGrid
);

    logic [63:0] grid;
    logic [63:0] next_grid;

    // Every cell's next value is derived purely from the registered grid, so all
    // 64 cells advance together; neighbour indices wrap mod 8 to form the torus.
    for (genvar r = 0; r < 8; r++) begin : g_row
        for (genvar c = 0; c < 8; c++) begin : g_col
            localparam int RU = (r + 7) % 8;
            localparam int RD = (r + 1) % 8;
            localparam int CL = (c + 7) % 8;
            localparam int CR = (c + 1) % 8;

            logic [3:0] n;

            assign n = {3'b000, grid[8*RU + CL]} + {3'b000, grid[8*RU + c]}
                     + {3'b000, grid[8*RU + CR]} + {3'b000, grid[8*r  + CL]}
                     + {3'b000, grid[8*r  + CR]} + {3'b000, grid[8*RD + CL]}
                     + {3'b000, grid[8*RD + c]}  + {3'b000, grid[8*RD + CR]};

            assign next_grid[8*r + c] = (n == 4'd3) | (grid[8*r + c] & (n == 4'd2));
        end
    end

    always_ff @(posedge clk or posedge start) begin
        if (start) begin
            grid <= SEED;
        end else begin
            grid <= next_grid;
        end
    end

    assign outGrid = grid;

endmodule

// File: tb/tb_game_of_life.sv
// tb/tb_game_of_life.sv - scoreboard bench for game_of_life against a torus-rule model
module tb_game_of_life;

    localparam int NDUT = 5;
    localparam int NCYC = 400;

    logic        clk;
    logic        start;
    logic [63:0] og [NDUT];
    logic [63:0] seeds [NDUT];

    typedef struct packed {
        logic [NDUT-1:0][63:0] v;
        int                    gen;
    } entry_t;

    entry_t sbq [$];
    int     errors = 0;
    int     checks = 0;
    bit     drv_done = 0;
    bit     mon_done = 0;

    game_of_life #(.SEED(64'h0000_0000_0007_0402)) u_glider (.clk(clk), .start(start), .outGrid(og[0]));
    game_of_life #(.SEED(64'h0000_0000_0000_0083)) u_blink  (.clk(clk), .start(start), .outGrid(og[1]));
    game_of_life #(.SEED(64'h0000_0000_0000_0000)) u_zero   (.clk(clk), .start(start), .outGrid(og[2]));
    game_of_life #(.SEED(64'h0000_0000_0000_0303)) u_block  (.clk(clk), .start(start), .outGrid(og[3]));
    game_of_life #(.SEED(64'h3C5A_81E7_0F66_D219)) u_rand   (.clk(clk), .start(start), .outGrid(og[4]));

    initial begin
        seeds = '{64'h0000_0000_0007_0402, 64'h0000_0000_0000_0083, 64'h0000_0000_0000_0000,
                  64'h0000_0000_0000_0303, 64'h3C5A_81E7_0F66_D219};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: count the eight wrapped neighbours of each cell by coordinates.
    function automatic logic [63:0] step(input logic [63:0] g);
        logic [63:0] nx;
        nx = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                int n;
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr != 0 || dc != 0) begin
                            n += int'(g[8*((r + dr + 8) % 8) + ((c + dc + 8) % 8)]);
                        end
                    end
                end
                nx[8*r + c] = (n == 3) || (g[8*r + c] && n == 2);
            end
        end
        return nx;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver: start changes 2 time units after the falling edge; the model is
    // overridden to the seed whenever start is high and stepped at each rising
    // edge that sees start low.
    initial begin
        logic [NDUT-1:0][63:0] m;
        int     gen;
        entry_t e;
        start = 1'b1;
        gen   = 0;
        for (int i = 0; i < NDUT; i++) m[i] = seeds[i];
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            #2;
            if (cyc < 3)        start = 1'b1;
            else if (cyc < 11)  start = 1'b0;
            else if (cyc == 11) start = 1'b1;
            else if (cyc < 40)  start = 1'b0;
            else if (cyc < 50)  start = 1'b1;
            else                start = ($urandom_range(0, 24) == 0);
            if (start) begin
                gen = 0;
                for (int i = 0; i < NDUT; i++) m[i] = seeds[i];
            end
            e.v   = m;
            e.gen = gen;
            sbq.push_back(e);
            @(posedge clk);
            if (!start) begin
                gen++;
                for (int i = 0; i < NDUT; i++) m[i] = step(m[i]);
            end
        end
        drv_done = 1'b1;
        for (int t = 0; t < 20 && !mon_done; t++) @(negedge clk);
        checks++;
        if (!mon_done || sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: monitor_done=%0d queue_left=%0d expected 1 and 0", mon_done, sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Monitor: samples 3 units after each falling edge, just after start may
    // have moved, so an asserted start must already show the seed with no edge.
    initial begin
        entry_t e;
        int     budget;
        budget = 0;
        while (!(drv_done && sbq.size() == 0) && budget < 2 * NCYC) begin
            @(negedge clk);
            #3;
            budget++;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                for (int i = 0; i < NDUT; i++) chk($sformatf("model_dut%0d_gen%0d", i, e.gen), og[i], e.v[i]);
                if (e.gen == 0) chk("glider_seed", og[0], 64'h0000_0000_0007_0402);
                if (e.gen == 1) chk("glider_gen1", og[0], 64'h0000_0000_0206_0500);
                if (e.gen == 4) chk("glider_gen4", og[0], 64'h0000_0000_0E08_0400);
                if (e.gen == 1) chk("blinker_gen1", og[1], 64'h0100_0000_0000_0101);
                if (e.gen == 2) chk("blinker_gen2", og[1], 64'h0000_0000_0000_0083);
                chk("zero_fixed", og[2], 64'h0);
                chk("block_fixed", og[3], 64'h0000_0000_0000_0303);
            end
        end
        mon_done = 1'b1;
    end

endmodule
